// File: rtl/uart_pkg.sv
// Shared UART definitions: the frame state enum, data width and baud divider helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int DATA_BITS = 8;

  // Clocks per bit; fractional divisors truncate, shared with the receiver.
  function automatic int bit_cycles(input int clk_mhz, input int baud);
    return (clk_mhz * 1_000_000) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Byte handshake between a producer (master) and the UART transmitter (slave).
interface uart_tx_frame_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Free-running bit-period counter; bit_end_o pulses on the last clock of each bit.
module uart_baud_gen #(
  parameter int BIT_CYCLES = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic bit_end_o
);

  localparam int CNT_W = (BIT_CYCLES < 2) ? 1 : $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);

  if (BIT_CYCLES < 2) begin : g_bad_divider
    $error("uart_baud_gen: BIT_CYCLES must be at least 2");
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_end_o = (cnt_q == LAST_CNT);

  // Clearing on frame start aligns the first bit period with the acceptance edge.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || bit_end_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert the even parity bit after the data bits.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_MHZ   = 50,
  parameter int BAUD      = 100_000,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_frame_if.slave    bus,
  output logic              tx,
  output logic              busy
);

  localparam int BIT_CYCLES = bit_cycles(CLK_MHZ, BAUD);
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  uart_state_e state_q;
  logic [7:0]  shift_q;
  logic [2:0]  idx_q;
  logic        stop_idx_q;
  logic        tx_q;
  logic        busy_q;
  logic        bit_end;
  logic        accept;
`ifdef UART_TX_PARITY_EN
  logic        par_q;
`endif

  assign bus.tx_ready = (state_q == IDLE) && !rst;
  assign accept       = bus.tx_valid && bus.tx_ready;
  assign tx           = tx_q;
  assign busy         = busy_q;

  uart_baud_gen #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (accept),
    .bit_end_o (bit_end)
  );

  // Frame sequencer; tx and busy are registered here so the line never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q    <= bus.tx_data;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= START;
`ifdef UART_TX_PARITY_EN
            par_q      <= ^bus.tx_data;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
              idx_q   <= idx_q + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          // A second stop bit reuses the same bit period via stop_idx_q.
          if (bit_end) begin
            if (STOP_BITS == 1 || stop_idx_q) begin
              busy_q     <= 1'b0;
              stop_idx_q <= 1'b0;
              state_q    <= IDLE;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: a default instance and a 2-stop-bit 115200 baud instance.
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic txA, busyA, txB, busyB;
  int   checks = 0;
  int   errors = 0;
  int   hsA = 0;
  int   hsB = 0;
  int   hsBase;

  always #5 clk = ~clk;

  uart_tx_frame_if ifA ();
  uart_tx_frame_if ifB ();

  uart_tx_frame dutA (
    .clk  (clk),
    .rst  (rst),
    .bus  (ifA),
    .tx   (txA),
    .busy (busyA)
  );

  uart_tx_frame #(
    .CLK_MHZ   (50),
    .BAUD      (115200),
    .STOP_BITS (2)
  ) dutB (
    .clk  (clk),
    .rst  (rst),
    .bus  (ifB),
    .tx   (txB),
    .busy (busyB)
  );

  // Count every accepted byte on each instance.
  always @(posedge clk) begin
    if (!rst && ifA.tx_valid && ifA.tx_ready) hsA++;
    if (!rst && ifB.tx_valid && ifB.tx_ready) hsB++;
  end

  function automatic logic txOf(input int sel);
    return (sel == 0) ? txA : txB;
  endfunction

  function automatic logic busyOf(input int sel);
    return (sel == 0) ? busyA : busyB;
  endfunction

  function automatic logic readyOf(input int sel);
    return (sel == 0) ? ifA.tx_ready : ifB.tx_ready;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Presents a byte for one handshake; returns at the negedge of the first start-bit clock.
  task automatic applyStimulus(input int sel, input logic [7:0] b, input bit hold);
    @(negedge clk);
    checkOutput($sformatf("ready before send sel%0d", sel), int'(readyOf(sel)), 1);
    if (sel == 0) begin
      ifA.tx_data = b; ifA.tx_valid = 1'b1;
    end else begin
      ifB.tx_data = b; ifB.tx_valid = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      if (sel == 0) ifA.tx_valid = 1'b0;
      else          ifB.tx_valid = 1'b0;
    end
  endtask

  // Compares every clock of a frame against the expected bit waveform, one check per bit.
  task automatic checkFrame(input string tag, input int sel, input logic [7:0] b,
                            input int bc, input int stopBits);
    logic e [0:11];
    int   n;
    int   bad;
    n = 1 + 8 + PAR_BITS + stopBits;
    for (int i = 0; i < 12; i++) e[i] = 1'b1;
    e[0] = 1'b0;
    for (int i = 0; i < 8; i++) e[1+i] = b[i];
    if (PAR_BITS == 1) e[9] = ^b;
    for (int i = 0; i < n; i++) begin
      bad = 0;
      for (int c = 0; c < bc; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        if (txOf(sel) !== e[i] || busyOf(sel) !== 1'b1 || readyOf(sel) !== 1'b0) bad++;
      end
      checkOutput($sformatf("%s bit%0d bad clocks", tag, i), bad, 0);
    end
    @(negedge clk);
    checkOutput($sformatf("%s end busy", tag), int'(busyOf(sel)), 0);
    checkOutput($sformatf("%s end ready", tag), int'(readyOf(sel)), 1);
    checkOutput($sformatf("%s end tx", tag), int'(txOf(sel)), 1);
  endtask

  initial begin
    rst = 1'b1;
    ifA.tx_data = 8'h00; ifA.tx_valid = 1'b0;
    ifB.tx_data = 8'h00; ifB.tx_valid = 1'b0;
    #2;
    checkOutput("reset txA", int'(txA), 1);
    checkOutput("reset busyA", int'(busyA), 0);
    checkOutput("reset readyA", int'(ifA.tx_ready), 0);
    checkOutput("reset txB", int'(txB), 1);
    checkOutput("reset busyB", int'(busyB), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("release readyA", int'(ifA.tx_ready), 1);
    checkOutput("release readyB", int'(ifB.tx_ready), 1);

    $display("[TB] step 1: 0x55 at defaults");
    applyStimulus(0, 8'h55, 1'b0);
    checkFrame("f55", 0, 8'h55, 500, 1);

    $display("[TB] step 2: 0x07 and 0x03");
    applyStimulus(0, 8'h07, 1'b0);
    checkFrame("f07", 0, 8'h07, 500, 1);
    applyStimulus(0, 8'h03, 1'b0);
    checkFrame("f03", 0, 8'h03, 500, 1);

    $display("[TB] step 3: back-to-back 0xA5 then 0x3C");
    hsBase = hsA;
    applyStimulus(0, 8'hA5, 1'b1);
    ifA.tx_data = 8'h3C;
    checkFrame("fA5", 0, 8'hA5, 500, 1);
    @(negedge clk);
    ifA.tx_valid = 1'b0;
    checkFrame("f3C", 0, 8'h3C, 500, 1);
    repeat (3) @(negedge clk);
    checkOutput("b2b handshakes", hsA - hsBase, 2);

    $display("[TB] step 4: 0x81 with data change mid-frame");
    hsBase = hsA;
    applyStimulus(0, 8'h81, 1'b0);
    fork
      checkFrame("f81", 0, 8'h81, 500, 1);
      begin
        repeat (2000) @(negedge clk);
        ifA.tx_data  = 8'hFF;
        ifA.tx_valid = 1'b1;
        repeat (1000) @(negedge clk);
        ifA.tx_valid = 1'b0;
      end
    join
    checkOutput("mid-frame handshakes", hsA - hsBase, 1);

    $display("[TB] step 5: reset mid-frame");
    applyStimulus(0, 8'h00, 1'b0);
    repeat (1700) @(negedge clk);
    checkOutput("pre-reset tx", int'(txA), 0);
    #1 rst = 1'b1;
    #1;
    checkOutput("async reset tx", int'(txA), 1);
    checkOutput("async reset busy", int'(busyA), 0);
    checkOutput("async reset ready", int'(ifA.tx_ready), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post-reset ready", int'(ifA.tx_ready), 1);
    checkOutput("post-reset tx", int'(txA), 1);
    applyStimulus(0, 8'h12, 1'b0);
    checkFrame("f12", 0, 8'h12, 500, 1);

    $display("[TB] step 6: 0xF0 at 115200 with two stop bits");
    hsBase = hsB;
    applyStimulus(1, 8'hF0, 1'b0);
    checkFrame("fF0", 1, 8'hF0, 434, 2);
    checkOutput("B handshakes", hsB - hsBase, 1);
    checkOutput("A idle during B", int'(txA), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmitter; the transmit-side counterpart to the team's UART receiver.
- Accepts one byte per valid/ready handshake and serialises it on a single line: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Sits between the byte-producing logic and the board TX pin.
- Bit timing is derived from the system clock by an integer baud divider.

Parameters:
- CLK_MHZ, 50, system clock frequency in MHz.
- BAUD, 100_000, line rate in bit/s.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.
- Derived localparams:
  - BIT_CYCLES = CLK_MHZ*1_000_000/BAUD, truncated (500 at defaults).
  - CNT_W = $clog2(BIT_CYCLES).
  - Elaboration error if BIT_CYCLES < 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_data  input  8  byte to send; sampled only on handshake.
- tx_valid  input  1  producer has a byte.
- tx_ready  output  1  block can accept a byte; high only in IDLE.
- tx  output  1  serial line, registered, idle-high.
- busy  output  1  high from the cycle after acceptance until the frame ends.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - tx=1, busy=0, state=IDLE, bit counter=0, shift register=0.
  - tx_ready=1 once rst deasserts; it is held low while rst=1.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - tx=1, tx_ready=1.
  - On tx_valid && tx_ready at edge N: latch tx_data into the shift register and enter START.
  - From edge N: tx=0, busy=1, tx_ready=0.
  - Latency from acceptance to start-bit edge is 1 clock.
- Bit timing:
  - A cycle counter counts 0..BIT_CYCLES-1.
  - Every bit, including each stop bit, holds tx for exactly BIT_CYCLES clocks.
  - The bit advances when the counter == BIT_CYCLES-1; the counter then wraps to 0.
- DATA:
  - 8 bits, LSB first; the shift register shifts right once per bit.
  - A 3-bit index counts 0..7; leave DATA after index 7.
- PARITY (only with the macro below): one bit equal to the even parity of the latched byte (XOR of its 8 bits).
- STOP:
  - tx=1 for STOP_BITS*BIT_CYCLES clocks, then IDLE.
  - busy drops and tx_ready rises on the same edge.
- Back-to-back:
  - A byte presented while tx_ready=1 in IDLE is accepted on the first IDLE cycle.
  - Minimum line-high time between frames is therefore STOP_BITS*BIT_CYCLES+1 clocks.
- Handshake rules:
  - tx_valid or tx_data changing while busy has no effect.
  - No byte is ever accepted or dropped outside a handshake.
- Reset mid-frame: the frame is aborted immediately, tx returns high asynchronously, and no partial state survives.
- No glitches on tx: it is driven directly from a flop.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state is present, the frame is 11 or 12 bits, and the parity is even.
- Undefined: the PARITY state and its logic are absent, DATA goes straight to STOP, and the frame is 10 or 11 bits.
- The port list is identical in both builds.

Decomposition:
- Package uart_pkg holds:
  - the state enum: IDLE, START, DATA, PARITY, STOP;
  - DATA_BITS = 8;
  - a function bit_cycles(clk_mhz, baud), shared with the receiver.
- One sub-module, uart_baud_gen:
  - a free counter with sync clear on frame start;
  - outputs a one-cycle bit_end strobe at count BIT_CYCLES-1;
  - parameterised by BIT_CYCLES.
- The FSM, shift register and parity stay in uart_tx_frame.

Test Plan:
1. Defaults, send 0x55:
   - tx is 0 starting the clock after the handshake.
   - Then 1,0,1,0,1,0,1,0 then 1, each held exactly 500 clocks.
   - busy high for 5000 clocks; tx_ready returns on the last edge.
2. UART_TX_PARITY_EN defined, send 0x07 then 0x03:
   - parity bit 1 for 0x07 and 0 for 0x03.
   - Each frame is 5500 clocks.
3. tx_valid held high with 0xA5 then 0x3C queued back-to-back:
   - both frames decode correctly.
   - Line is high for exactly 501 clocks between the two stop/start boundaries.
   - Exactly two handshakes occur.
4. tx_data changed to 0xFF in the middle of the 0x81 frame:
   - the transmitted bits still decode as 0x81.
5. rst asserted 1700 clocks into a frame:
   - tx goes to 1 without waiting for a clock edge; busy=0.
   - After release, tx_ready=1 and a new 0x12 frame is transmitted cleanly.
6. STOP_BITS=2, BAUD=115200 (BIT_CYCLES=434), send 0xF0:
   - each bit lasts 434 clocks.
   - The stop interval is 868 clocks before tx_ready rises.
